// File: rtl/race_pkg.sv
// ---------------------------------------------------------------------------
// race_pkg
// Shared types and helpers for the race phase controller.
//   phase_t        : race phase encoding exported on the phase output
//   FRAMES_PER_SEC : frame rate used to turn frame counts into HUD seconds
//   TMR_W          : width of the frame timers
//   secs_left()    : ceil(frames / FRAMES_PER_SEC), truncated to 2 bits
// ---------------------------------------------------------------------------
package race_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        RACING    = 3'd2,
        CRASHED   = 3'd3,
        FINISHED  = 3'd4,
        GAMEOVER  = 3'd5
    } phase_t;

    localparam int unsigned FRAMES_PER_SEC = 30;
    localparam int unsigned TMR_W          = 8;

    function automatic logic [1:0] secs_left(input logic [TMR_W-1:0] frames);
        int unsigned s;
        s = (32'(frames) + FRAMES_PER_SEC - 1) / FRAMES_PER_SEC;
        return s[1:0];
    endfunction

endpackage

// File: rtl/race_phase_controller_if.sv
// ---------------------------------------------------------------------------
// race_phase_controller_if
// Bundles the frame-rate inputs from the input/collision logic and the
// outputs consumed by the HUD/scroll logic.
//   startOfFrame   : one-clk pulse per frame
//   start_btn      : level, rising edge requests a race start
//   crash          : one-clk collision pulse
//   fuel_pickup    : one-clk pickup pulse
//   player_speed   : unsigned speed
//   phase          : current race phase
//   distance_drove : distance covered in this race
//   fuel           : fuel level
//   countdown_sec  : HUD countdown seconds (3..1), 0 outside countdown
//   speed_enable   : high only while racing
// master drives the inputs (game logic / bench), slave is the controller.
// ---------------------------------------------------------------------------
interface race_phase_controller_if;
    import race_pkg::*;

    logic        startOfFrame;
    logic        start_btn;
    logic        crash;
    logic        fuel_pickup;
    logic [9:0]  player_speed;
    phase_t      phase;
    logic [31:0] distance_drove;
    logic [7:0]  fuel;
    logic [1:0]  countdown_sec;
    logic        speed_enable;

    modport master (
        output startOfFrame, start_btn, crash, fuel_pickup, player_speed,
        input  phase, distance_drove, fuel, countdown_sec, speed_enable
    );

    modport slave (
        input  startOfFrame, start_btn, crash, fuel_pickup, player_speed,
        output phase, distance_drove, fuel, countdown_sec, speed_enable
    );

endinterface

// File: rtl/frame_timer.sv
// ---------------------------------------------------------------------------
// frame_timer
// Loadable down-counter advanced by a frame tick; stops at zero.
//   clk, resetN   : clock, async active-low reset
//   load_i        : load load_val_i (wins over tick_i)
//   load_val_i    : value to load
//   tick_i        : decrement by one when non-zero
//   count_o       : current count
//   zero_o        : count is zero
// ---------------------------------------------------------------------------
module frame_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/race_phase_controller.sv
// ---------------------------------------------------------------------------
// race_phase_controller
// Frame-rate race sequencer: idle, countdown, racing (with crash recovery),
// finished / game-over. Owns distance, fuel and the HUD countdown.
// All state moves on startOfFrame; outputs are registered.
//   clk, resetN : clock, async active-low reset
//   bus         : race_phase_controller_if.slave (see interface header)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a start edge
// COUNTDOWN | pre-race countdown, HUD shows seconds left
// RACING    | distance accumulates, fuel burns, speed enabled
// CRASHED   | recovery, distance frozen, fuel still burns
// FINISHED  | track length reached, outputs hold until start edge
// GAMEOVER  | fuel exhausted, outputs hold until start edge
// ---------------------------------------------------------------------------
module race_phase_controller
    import race_pkg::*;
#(
    parameter int unsigned TRACK_LEN        = 20000,
    parameter int unsigned COUNTDOWN_FRAMES = 90,
    parameter int unsigned CRASH_FRAMES     = 60,
    parameter int unsigned FUEL_MAX         = 100,
    parameter int unsigned FUEL_DEC_FRAMES  = 30,
    parameter int unsigned FUEL_PICKUP      = 25,
    parameter int unsigned SPEED_SHIFT      = 5
) (
    input  logic                   clk,
    input  logic                   resetN,
    race_phase_controller_if.slave bus
);

    localparam logic [31:0]      TRACK_LEN_C   = 32'(TRACK_LEN);
    localparam logic [7:0]       FUEL_MAX_C    = 8'(FUEL_MAX);
    localparam logic [8:0]       FUEL_PICKUP_C = 9'(FUEL_PICKUP);
    localparam logic [TMR_W-1:0] CD_LOAD       = TMR_W'(COUNTDOWN_FRAMES);
    localparam logic [TMR_W-1:0] CRASH_LOAD    = TMR_W'(CRASH_FRAMES);
    localparam logic [TMR_W-1:0] FDIV_LOAD     = TMR_W'(FUEL_DEC_FRAMES);

    phase_t      phase_q, phase_d;
    logic [31:0] distance_q, distance_d;
    logic [7:0]  fuel_q, fuel_d;
    logic [1:0]  cd_sec_q, cd_sec_d;
    logic        speed_en_q, speed_en_d;

    logic start_prev_q;
    logic pend_start_q, pend_start_d;
    logic pend_crash_q, pend_crash_d;
    logic pend_pick_q, pend_pick_d;

    logic sof;
    logic start_edge;
    logic start_ev, crash_ev, pick_ev;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic [TMR_W-1:0] tmr_cnt;
    logic             tmr_zero;
    logic             tmr_expire;

    logic             fdiv_load;
    logic             fdiv_tick;
    logic [TMR_W-1:0] fdiv_cnt;
    logic             fdiv_zero;
    logic             fdiv_expire;

    logic [31:0] speed_inc;
    logic [31:0] dist_sum;
    logic [31:0] dist_sat;
    logic        dist_hit;
    logic [7:0]  fuel_dec;
    logic [8:0]  fuel_sum;
    logic [7:0]  fuel_new;

    // -----------------------------------------------------------------------
    // Event latching: an event raised at any clk is held until the next frame;
    // one that lands on the frame pulse itself is used directly.
    // -----------------------------------------------------------------------
    assign sof        = bus.startOfFrame;
    assign start_edge = bus.start_btn & ~start_prev_q;
    assign start_ev   = pend_start_q | start_edge;
    assign crash_ev   = pend_crash_q | bus.crash;
    assign pick_ev    = pend_pick_q  | bus.fuel_pickup;

    // Every frame consumes the flags, whether or not the phase acts on them.
    assign pend_start_d = sof ? 1'b0 : start_ev;
    assign pend_crash_d = sof ? 1'b0 : crash_ev;
    assign pend_pick_d  = sof ? 1'b0 : pick_ev;

    // -----------------------------------------------------------------------
    // Timers: one shared by countdown and crash recovery, one as the fuel
    // divider. "Expire" means this frame takes the count to zero.
    // -----------------------------------------------------------------------
    frame_timer #(.W(TMR_W)) u_phase_tmr (
        .clk        (clk),
        .resetN     (resetN),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .tick_i     (sof),
        .count_o    (tmr_cnt),
        .zero_o     (tmr_zero)
    );

    frame_timer #(.W(TMR_W)) u_fuel_div (
        .clk        (clk),
        .resetN     (resetN),
        .load_i     (fdiv_load),
        .load_val_i (FDIV_LOAD),
        .tick_i     (fdiv_tick),
        .count_o    (fdiv_cnt),
        .zero_o     (fdiv_zero)
    );

    assign tmr_expire  = tmr_zero  | (tmr_cnt  == TMR_W'(1));
    assign fdiv_expire = fdiv_zero | (fdiv_cnt == TMR_W'(1));

    // -----------------------------------------------------------------------
    // Datapath: distance add clamped to track length; fuel burn then pickup,
    // so a pickup on the emptying frame keeps the race alive.
    // -----------------------------------------------------------------------
    assign speed_inc = 32'(bus.player_speed >> SPEED_SHIFT);
    assign dist_sum  = distance_q + speed_inc;
    assign dist_hit  = (dist_sum >= TRACK_LEN_C);
    assign dist_sat  = dist_hit ? TRACK_LEN_C : dist_sum;

    assign fuel_dec  = (fdiv_expire && (fuel_q != 8'd0)) ? (fuel_q - 8'd1) : fuel_q;
    assign fuel_sum  = {1'b0, fuel_dec} + FUEL_PICKUP_C;

    always_comb begin
        fuel_new = fuel_dec;
        if (pick_ev) begin
            fuel_new = (fuel_sum > {1'b0, FUEL_MAX_C}) ? FUEL_MAX_C : fuel_sum[7:0];
        end
    end

    // -----------------------------------------------------------------------
    // Phase FSM
    // -----------------------------------------------------------------------
    always_comb begin
        phase_d      = phase_q;
        distance_d   = distance_q;
        fuel_d       = fuel_q;
        cd_sec_d     = cd_sec_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        fdiv_load    = 1'b0;
        fdiv_tick    = 1'b0;

        if (sof) begin
            unique case (phase_q)
                IDLE: begin
                    if (start_ev) begin
                        phase_d      = COUNTDOWN;
                        tmr_load     = 1'b1;
                        tmr_load_val = CD_LOAD;
                        distance_d   = '0;
                        fuel_d       = FUEL_MAX_C;
                        cd_sec_d     = secs_left(CD_LOAD);
                    end
                end

                COUNTDOWN: begin
                    if (tmr_expire) begin
                        phase_d   = RACING;
                        cd_sec_d  = 2'd0;
                        fdiv_load = 1'b1;
                    end else begin
                        cd_sec_d  = secs_left(tmr_cnt - TMR_W'(1));
                    end
                end

                RACING: begin
                    fdiv_tick = 1'b1;
                    fdiv_load = fdiv_expire;
                    fuel_d    = fuel_new;
                    if (crash_ev) begin
                        phase_d      = CRASHED;
                        tmr_load     = 1'b1;
                        tmr_load_val = CRASH_LOAD;
                    end else begin
                        distance_d = dist_sat;
                        if (dist_hit) begin
                            phase_d = FINISHED;
                        end
                    end
                    // Crossing the line beats running dry on the same frame.
                    if ((fuel_new == 8'd0) && !(dist_hit && !crash_ev)) begin
                        phase_d = GAMEOVER;
                    end
                end

                CRASHED: begin
                    fdiv_tick = 1'b1;
                    fdiv_load = fdiv_expire;
                    fuel_d    = fuel_new;
                    if (tmr_expire) begin
                        phase_d = RACING;
                    end
                    if (fuel_new == 8'd0) begin
                        phase_d = GAMEOVER;
                    end
                end

                FINISHED, GAMEOVER: begin
                    if (start_ev) begin
                        phase_d = IDLE;
                    end
                end

                default: begin
                    phase_d = IDLE;
                end
            endcase
        end
    end

    assign speed_en_d = (phase_d == RACING);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            phase_q      <= IDLE;
            distance_q   <= '0;
            fuel_q       <= FUEL_MAX_C;
            cd_sec_q     <= 2'd0;
            speed_en_q   <= 1'b0;
            start_prev_q <= 1'b0;
            pend_start_q <= 1'b0;
            pend_crash_q <= 1'b0;
            pend_pick_q  <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            distance_q   <= distance_d;
            fuel_q       <= fuel_d;
            cd_sec_q     <= cd_sec_d;
            speed_en_q   <= speed_en_d;
            start_prev_q <= bus.start_btn;
            pend_start_q <= pend_start_d;
            pend_crash_q <= pend_crash_d;
            pend_pick_q  <= pend_pick_d;
        end
    end

    assign bus.phase          = phase_q;
    assign bus.distance_drove = distance_q;
    assign bus.fuel           = fuel_q;
    assign bus.countdown_sec  = cd_sec_q;
    assign bus.speed_enable   = speed_en_q;

endmodule

// File: tb/tb_race_phase_controller.sv
// ---------------------------------------------------------------------------
// tb_race_phase_controller
// Directed race scenarios followed by randomized play, every clk compared
// against a frame-level model of the race rules.
// ---------------------------------------------------------------------------
module tb_race_phase_controller;
    import race_pkg::*;

    logic clk = 1'b0;
    logic resetN;

    always #5 clk = ~clk;

    race_phase_controller_if bus();

    race_phase_controller dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int n_tests;
    int n_fail;

    // reference model state
    phase_t m_phase;
    int     m_dist;
    int     m_fuel;
    int     m_left;
    int     m_race_frames;
    int     m_speed;
    bit     m_ps, m_pc, m_pp;
    bit     m_st_prev;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase       = IDLE;
        m_dist        = 0;
        m_fuel        = 100;
        m_left        = 0;
        m_race_frames = 0;
        m_ps          = 0;
        m_pc          = 0;
        m_pp          = 0;
        m_st_prev     = 0;
    endtask

    // One frame of race rules applied to the events gathered since the last frame.
    task automatic model_frame();
        phase_t nxt;
        bit     fin;
        nxt = m_phase;
        fin = 0;
        case (m_phase)
            IDLE: begin
                if (m_ps) begin
                    nxt    = COUNTDOWN;
                    m_left = 90;
                    m_dist = 0;
                    m_fuel = 100;
                end
            end
            COUNTDOWN: begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    nxt           = RACING;
                    m_race_frames = 0;
                end
            end
            RACING, CRASHED: begin
                m_race_frames = m_race_frames + 1;
                if ((m_race_frames % 30) == 0 && m_fuel > 0) m_fuel = m_fuel - 1;
                if (m_pp) m_fuel = (m_fuel + 25 > 100) ? 100 : m_fuel + 25;
                if (m_phase == RACING) begin
                    if (m_pc) begin
                        nxt    = CRASHED;
                        m_left = 60;
                    end else begin
                        m_dist = m_dist + m_speed / 32;
                        if (m_dist >= 20000) begin
                            m_dist = 20000;
                            fin    = 1;
                            nxt    = FINISHED;
                        end
                    end
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) nxt = RACING;
                end
                if (m_fuel == 0 && !fin) nxt = GAMEOVER;
            end
            default: begin
                if (m_ps) nxt = IDLE;
            end
        endcase
        m_phase = nxt;
    endtask

    task automatic check_outputs();
        int exp_sec;
        exp_sec = (m_phase == COUNTDOWN) ? (m_left + 29) / 30 : 0;
        check_val("phase",         32'(bus.phase),         32'(m_phase));
        check_val("distance",      bus.distance_drove,     32'(m_dist));
        check_val("fuel",          32'(bus.fuel),          32'(m_fuel));
        check_val("countdown_sec", 32'(bus.countdown_sec), 32'(exp_sec));
        check_val("speed_enable",  32'(bus.speed_enable),  32'(m_phase == RACING));
    endtask

    // One clk: drive at negedge, model on posedge, compare at the next negedge.
    task automatic cyc(input bit sof, input bit st, input bit cr, input bit pk);
        bus.startOfFrame = sof;
        bus.start_btn    = st;
        bus.crash        = cr;
        bus.fuel_pickup  = pk;
        bus.player_speed = 10'(m_speed);
        if (st && !m_st_prev) m_ps = 1;
        m_st_prev = st;
        if (cr) m_pc = 1;
        if (pk) m_pp = 1;
        @(posedge clk);
        if (sof) begin
            model_frame();
            m_ps = 0;
            m_pc = 0;
            m_pp = 0;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic frame(input bit st, input bit cr, input bit pk);
        int gap;
        gap = $urandom_range(2, 1);
        for (int i = 0; i < gap; i++) cyc(0, 0, 0, 0);
        cyc(1, st, cr, pk);
    endtask

    task automatic rand_frame();
        int gap;
        gap     = $urandom_range(3, 1);
        m_speed = $urandom_range(1023, 0);
        for (int i = 0; i < gap; i++)
            cyc(0, $urandom_range(39, 0) == 0, $urandom_range(29, 0) == 0, $urandom_range(11, 0) == 0);
        cyc(1, $urandom_range(39, 0) == 0, $urandom_range(29, 0) == 0, $urandom_range(11, 0) == 0);
    endtask

    task automatic start_race();
        cyc(0, 1, 0, 0);
        frame(0, 0, 0);
        check_val("start_phase", 32'(bus.phase), 32'(COUNTDOWN));
        repeat (90) frame(0, 0, 0);
        check_val("race_phase", 32'(bus.phase), 32'(RACING));
    endtask

    task automatic run_to_fuel_one(input string tag);
        for (int g = 0; g < 4000 && m_fuel != 1; g++) frame(0, 0, 0);
        check_val(tag, 32'(bus.fuel), 32'd1);
        for (int g = 0; g < 40 && ((m_race_frames + 1) % 30) != 0; g++) frame(0, 0, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_speed = 0;
        model_reset();
        resetN           = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.start_btn    = 1'b0;
        bus.crash        = 1'b0;
        bus.fuel_pickup  = 1'b0;
        bus.player_speed = '0;
        repeat (3) @(negedge clk);
        check_outputs();
        check_val("rst_fuel", 32'(bus.fuel), 32'd100);
        resetN = 1'b1;

        // Countdown HUD sequence and race start
        cyc(0, 1, 0, 0);
        frame(0, 0, 0);
        check_val("cd_enter", 32'(bus.phase), 32'(COUNTDOWN));
        for (int i = 1; i <= 90; i++) begin
            check_val("cd_sec", 32'(bus.countdown_sec), 32'(3 - (i - 1) / 30));
            frame(0, 0, 0);
        end
        check_val("cd_done_phase", 32'(bus.phase), 32'(RACING));
        check_val("cd_done_speed_en", 32'(bus.speed_enable), 32'd1);

        // Reset in the middle of a race
        m_speed = 640;
        repeat (250) frame(0, 0, 0);
        check_val("mid_race_dist", bus.distance_drove, 32'd5000);
        #2 resetN = 1'b0;
        #1;
        check_val("async_rst_phase", 32'(bus.phase), 32'(IDLE));
        check_val("async_rst_dist", bus.distance_drove, 32'd0);
        check_val("async_rst_fuel", 32'(bus.fuel), 32'd100);
        check_val("async_rst_speed_en", 32'(bus.speed_enable), 32'd0);
        model_reset();
        @(negedge clk);
        resetN = 1'b1;

        // Full race to the finish line at 20 units per frame
        start_race();
        repeat (999) frame(0, 0, 0);
        check_val("pre_finish_dist", bus.distance_drove, 32'd19980);
        frame(0, 0, 0);
        check_val("finish_dist", bus.distance_drove, 32'd20000);
        check_val("finish_phase", 32'(bus.phase), 32'(FINISHED));
        repeat (5) frame(0, 0, 0);
        check_val("finish_hold", bus.distance_drove, 32'd20000);

        // Crash recovery with a second crash ignored
        cyc(0, 1, 0, 0);
        frame(0, 0, 0);
        check_val("to_idle", 32'(bus.phase), 32'(IDLE));
        start_race();
        m_speed = 480;
        repeat (20) frame(0, 0, 0);
        check_val("crash_pre_dist", bus.distance_drove, 32'd300);
        cyc(0, 0, 1, 0);
        frame(0, 0, 0);
        check_val("crash_phase", 32'(bus.phase), 32'(CRASHED));
        for (int i = 1; i <= 59; i++) begin
            frame(0, i == 10, 0);
            check_val("crash_hold_phase", 32'(bus.phase), 32'(CRASHED));
            check_val("crash_hold_dist", bus.distance_drove, 32'd300);
        end
        frame(0, 0, 0);
        check_val("crash_exit_phase", 32'(bus.phase), 32'(RACING));
        check_val("crash_exit_dist", bus.distance_drove, 32'd300);

        // Pickup on the emptying frame, then running dry
        m_speed = 0;
        run_to_fuel_one("fuel_one_a");
        frame(0, 0, 1);
        check_val("pickup_save_fuel", 32'(bus.fuel), 32'd25);
        check_val("pickup_save_phase", 32'(bus.phase), 32'(RACING));
        run_to_fuel_one("fuel_one_b");
        frame(0, 0, 0);
        check_val("empty_fuel", 32'(bus.fuel), 32'd0);
        check_val("empty_phase", 32'(bus.phase), 32'(GAMEOVER));
        check_val("empty_speed_en", 32'(bus.speed_enable), 32'd0);

        // Finish and fuel exhaustion on the same frame
        cyc(0, 1, 0, 0);
        frame(0, 0, 0);
        check_val("go_to_idle", 32'(bus.phase), 32'(IDLE));
        start_race();
        m_speed = 0;
        repeat (2000) frame(0, 0, 0);
        m_speed = 640;
        repeat (999) frame(0, 0, 0);
        check_val("tie_pre_fuel", 32'(bus.fuel), 32'd1);
        frame(0, 0, 0);
        check_val("tie_phase", 32'(bus.phase), 32'(FINISHED));
        check_val("tie_dist", bus.distance_drove, 32'd20000);
        check_val("tie_fuel", 32'(bus.fuel), 32'd0);
        cyc(0, 1, 0, 0);
        frame(0, 0, 0);
        check_val("tie_idle", 32'(bus.phase), 32'(IDLE));
        cyc(0, 1, 0, 0);
        frame(0, 0, 0);
        check_val("tie_restart", 32'(bus.phase), 32'(COUNTDOWN));
        check_val("tie_restart_sec", 32'(bus.countdown_sec), 32'd3);

        // Randomized play
        for (int f = 0; f < 2500; f++) rand_frame();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
